// File: rtl/key_fifo_pkg.sv
// rtl/key_fifo_pkg.sv - shared constants, FSM state type and status packing for key_fifo_ctrl
package key_fifo_pkg;

  // Status register bit positions (count occupies bits 7:0)
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 15;

  // Control register bit positions
  localparam int CTRL_FLUSH   = 0;
  localparam int CTRL_CLR_OVF = 1;

  // Register offsets from Key_base
  localparam logic [3:0] REG_DATA_OFS = 4'h0;
  localparam logic [3:0] REG_STAT_OFS = 4'h8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Build the 64-bit status word returned on a status-register read
  function automatic logic [63:0] pack_status(input logic ovf, input logic full,
                                              input logic empty, input logic [7:0] count);
    logic [63:0] s;
    s             = '0;
    s[7:0]        = count;
    s[STAT_EMPTY] = empty;
    s[STAT_FULL]  = full;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with push/pop/flush and full/empty/count
module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_pop;
  logic              do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer values; flush discards everything including a same-cycle push
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/key_fifo_ctrl.sv
// rtl/key_fifo_ctrl.sv - keyboard receive FIFO with CPU bus registers and IRQ handshake (optional KEY_FIFO_BREAK_EN)
module key_fifo_ctrl
  import key_fifo_pkg::*;
#(
  parameter int         DEPTH   = 16,
  parameter int         DATA_W  = 8,
  parameter logic [3:0] IRQ_VEC = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_pressed,
  input  logic [DATA_W-1:0] key_ascii,
`ifdef KEY_FIFO_BREAK_EN
  input  logic              key_released,
`endif
  input  logic              bus_read_enable,
  input  logic              bus_write_enable,
  input  logic [63:0]       bus_write_data,
  input  logic              key_sel,
  input  logic              stat_sel,
  output logic [63:0]       bus_read_data,
  output logic [3:0]        irq_vector,
  input  logic              irq_ack,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic              kp_q;
  logic              rd_key_q, rd_stat_q, wr_stat_q;
  logic              ovf_q, ovf_d;
  logic [63:0]       rdata_q, rdata_d;
  irq_state_e        state_q;
  logic [3:0]        irq_q;

  logic              rd_key_lvl, rd_stat_lvl, wr_stat_lvl;
  logic              rd_key_pulse, rd_stat_pulse, wr_stat_pulse;
  logic              press_push;
  logic              push_req;
  logic [DATA_W-1:0] push_data;
  logic              flush;
  logic              clr_ovf;
  logic              ovf_set;

  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic              unused_wdata;
  assign unused_wdata = ^bus_write_data[63:2];

  assign rd_key_lvl    = bus_read_enable && key_sel;
  assign rd_stat_lvl   = bus_read_enable && stat_sel;
  assign wr_stat_lvl   = bus_write_enable && stat_sel;
  assign rd_key_pulse  = rd_key_lvl && !rd_key_q;
  assign rd_stat_pulse = rd_stat_lvl && !rd_stat_q;
  assign wr_stat_pulse = wr_stat_lvl && !wr_stat_q;

  assign press_push = key_pressed && !kp_q && (key_ascii != '0);
  assign flush      = wr_stat_pulse && bus_write_data[CTRL_FLUSH];
  assign clr_ovf    = wr_stat_pulse && bus_write_data[CTRL_CLR_OVF];

`ifdef KEY_FIFO_BREAK_EN
  logic              kr_q;
  logic              have_press_q;
  logic [DATA_W-1:0] last_press_q;
  logic [DATA_W-1:0] break_code;
  logic              rel_push;

  // Release pushes the last press code with bit 7 set; a same-cycle press takes precedence
  assign rel_push = key_released && !kr_q && have_press_q && !press_push;

  // Break code formed from the remembered press
  always_comb begin
    break_code      = '0;
    break_code[6:0] = last_press_q[6:0];
    break_code[7]   = 1'b1;
  end

  assign push_req  = press_push || rel_push;
  assign push_data = press_push ? key_ascii : break_code;

  // Release edge detect and memory of the most recent accepted press
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kr_q         <= 1'b0;
      have_press_q <= 1'b0;
      last_press_q <= '0;
    end else begin
      kr_q <= key_released;
      if (press_push) begin
        have_press_q <= 1'b1;
        last_press_q <= key_ascii;
      end
    end
  end
`else
  assign push_req  = press_push;
  assign push_data = key_ascii;
`endif

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_req),
    .push_data_i (push_data),
    .pop_i       (rd_key_pulse),
    .flush_i     (flush),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // A push is lost only when full with no pop to make room; flush discards rather than overflows
  assign ovf_set = push_req && fifo_full && !(rd_key_pulse && !fifo_empty) && !flush;

  // Overflow flag and read-data next state; set beats clear, data read beats status read
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    rdata_d = rdata_q;
    if (rd_key_pulse) begin
      rdata_d = fifo_empty ? 64'd0 : {{(64-DATA_W){1'b0}}, fifo_head};
    end else if (rd_stat_pulse) begin
      rdata_d = pack_status(ovf_q, fifo_full, fifo_empty, 8'(fifo_count));
    end
  end

  // Strobe edge detectors, overflow flag and registered read data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kp_q      <= 1'b0;
      rd_key_q  <= 1'b0;
      rd_stat_q <= 1'b0;
      wr_stat_q <= 1'b0;
      ovf_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      kp_q      <= key_pressed;
      rd_key_q  <= rd_key_lvl;
      rd_stat_q <= rd_stat_lvl;
      wr_stat_q <= wr_stat_lvl;
      ovf_q     <= ovf_d;
      rdata_q   <= rdata_d;
    end
  end

  // Interrupt FSM with registered vector; flush returns it to IDLE from any state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      irq_q   <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      irq_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_q <= PENDING;
            irq_q   <= IRQ_VEC;
          end
        end
        PENDING: begin
          if (irq_ack) begin
            state_q <= SERVICE;
            irq_q   <= '0;
          end
        end
        SERVICE: begin
          if (fifo_empty) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq_q   <= '0;
        end
      endcase
    end
  end

  assign bus_read_data = rdata_q;
  assign irq_vector    = irq_q;
  assign overflow      = ovf_q;

endmodule

// File: tb/tb_key_fifo_ctrl.sv
// tb/tb_key_fifo_ctrl.sv - self-checking bench for key_fifo_ctrl
module tb_key_fifo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_pressed;
  logic [7:0]  key_ascii;
`ifdef KEY_FIFO_BREAK_EN
  logic        key_released;
`endif
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [63:0] bus_write_data;
  logic        key_sel;
  logic        stat_sel;
  logic [63:0] bus_read_data;
  logic [3:0]  irq_vector;
  logic        irq_ack;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  localparam int OP_PRESS = 0;
  localparam int OP_RDATA = 1;
  localparam int OP_RSTAT = 2;
  localparam int OP_WCTRL = 3;
  localparam int OP_ACK   = 4;
  localparam int OP_IRQ   = 5;

  typedef struct {
    int          op;
    logic [63:0] arg;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  key_fifo_ctrl #(.DEPTH(16), .DATA_W(8), .IRQ_VEC(4'd1)) dut (
    .clk              (clk),
    .reset            (reset),
    .key_pressed      (key_pressed),
    .key_ascii        (key_ascii),
`ifdef KEY_FIFO_BREAK_EN
    .key_released     (key_released),
`endif
    .bus_read_enable  (bus_read_enable),
    .bus_write_enable (bus_write_enable),
    .bus_write_data   (bus_write_data),
    .key_sel          (key_sel),
    .stat_sel         (stat_sel),
    .bus_read_data    (bus_read_data),
    .irq_vector       (irq_vector),
    .irq_ack          (irq_ack),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input logic [7:0] code);
    key_pressed = 1'b1;
    key_ascii   = code;
    tick();
    key_pressed = 1'b0;
    tick();
  endtask

  task automatic read_data(output logic [63:0] v);
    bus_read_enable = 1'b1;
    key_sel         = 1'b1;
    tick();
    v               = bus_read_data;
    bus_read_enable = 1'b0;
    key_sel         = 1'b0;
    tick();
  endtask

  task automatic read_stat(output logic [63:0] v);
    bus_read_enable = 1'b1;
    stat_sel        = 1'b1;
    tick();
    v               = bus_read_data;
    bus_read_enable = 1'b0;
    stat_sel        = 1'b0;
    tick();
  endtask

  task automatic write_ctrl(input logic [63:0] d);
    bus_write_enable = 1'b1;
    stat_sel         = 1'b1;
    bus_write_data   = d;
    tick();
    bus_write_enable = 1'b0;
    stat_sel         = 1'b0;
    bus_write_data   = '0;
    tick();
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    tick();
  endtask

  task automatic add(input int op, input logic [63:0] arg, input logic [63:0] exp);
    vec_t v;
    v.op  = op;
    v.arg = arg;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    logic [63:0] v;

    reset            = 1'b1;
    key_pressed      = 1'b0;
    key_ascii        = '0;
`ifdef KEY_FIFO_BREAK_EN
    key_released     = 1'b0;
`endif
    bus_read_enable  = 1'b0;
    bus_write_enable = 1'b0;
    bus_write_data   = '0;
    key_sel          = 1'b0;
    stat_sel         = 1'b0;
    irq_ack          = 1'b0;

    // Basic press/read/status, IRQ handshake, zero code, empty read and flush
    add(OP_PRESS, 64'h41, 0);
    add(OP_IRQ,   0, 64'h1);
    add(OP_RDATA, 0, 64'h41);
    add(OP_RSTAT, 0, 64'h100);
    add(OP_IRQ,   0, 64'h1);
    add(OP_ACK,   0, 0);
    add(OP_IRQ,   0, 64'h0);
    add(OP_ACK,   0, 0);
    add(OP_IRQ,   0, 64'h0);
    add(OP_PRESS, 64'h42, 0);
    add(OP_PRESS, 64'h43, 0);
    add(OP_IRQ,   0, 64'h1);
    add(OP_RSTAT, 0, 64'h002);
    add(OP_ACK,   0, 0);
    add(OP_IRQ,   0, 64'h0);
    add(OP_RDATA, 0, 64'h42);
    add(OP_IRQ,   0, 64'h0);
    add(OP_RDATA, 0, 64'h43);
    add(OP_IRQ,   0, 64'h0);
    add(OP_PRESS, 64'h44, 0);
    add(OP_IRQ,   0, 64'h1);
    add(OP_RDATA, 0, 64'h44);
    add(OP_ACK,   0, 0);
    add(OP_IRQ,   0, 64'h0);
    add(OP_PRESS, 64'h00, 0);
    add(OP_RSTAT, 0, 64'h100);
    add(OP_RDATA, 0, 64'h0);
    add(OP_PRESS, 64'h45, 0);
    add(OP_PRESS, 64'h46, 0);
    add(OP_IRQ,   0, 64'h1);
    add(OP_WCTRL, 64'h1, 0);
    add(OP_RSTAT, 0, 64'h100);
    add(OP_IRQ,   0, 64'h0);

    tick(2);
    chk("reset_rdata", bus_read_data, 64'h0);
    chk("reset_irq", {60'd0, irq_vector}, 64'h0);
    chk("reset_ovf", {63'd0, overflow}, 64'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        OP_PRESS: press(tbl[i].arg[7:0]);
        OP_RDATA: begin
          read_data(v);
          chk($sformatf("vec%0d_rdata", i), v, tbl[i].exp);
        end
        OP_RSTAT: begin
          read_stat(v);
          chk($sformatf("vec%0d_status", i), v, tbl[i].exp);
        end
        OP_WCTRL: write_ctrl(tbl[i].arg);
        OP_ACK:   ack_pulse();
        OP_IRQ:   chk($sformatf("vec%0d_irq", i), {60'd0, irq_vector}, tbl[i].exp);
        default:  ;
      endcase
    end

    // Held read strobe pops exactly once
    press(8'h31);
    press(8'h32);
    press(8'h33);
    bus_read_enable = 1'b1;
    key_sel         = 1'b1;
    tick(50);
    chk("hold_rdata", bus_read_data, 64'h31);
    bus_read_enable = 1'b0;
    key_sel         = 1'b0;
    tick();
    read_stat(v);
    chk("hold_status", v, 64'h002);
    write_ctrl(64'h1);

    // Seventeen pushes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) press(8'(8'h50 + i));
    read_stat(v);
    chk("full_status", v, 64'h8210);
    chk("full_ovf", {63'd0, overflow}, 64'h1);
    write_ctrl(64'h2);
    read_stat(v);
    chk("clr_status", v, 64'h0210);
    chk("clr_ovf", {63'd0, overflow}, 64'h0);

    // Push and data read in the same cycle while full
    key_pressed     = 1'b1;
    key_ascii       = 8'h60;
    bus_read_enable = 1'b1;
    key_sel         = 1'b1;
    tick();
    chk("fullpp_rdata", bus_read_data, 64'h50);
    key_pressed     = 1'b0;
    bus_read_enable = 1'b0;
    key_sel         = 1'b0;
    tick();
    read_stat(v);
    chk("fullpp_status", v, 64'h0210);
    chk("fullpp_ovf", {63'd0, overflow}, 64'h0);
    for (int i = 1; i < 16; i++) begin
      read_data(v);
      chk($sformatf("drain%0d", i), v, 64'(8'h50 + i));
    end
    read_data(v);
    chk("drain_tail", v, 64'h60);
    read_stat(v);
    chk("drain_status", v, 64'h100);
    write_ctrl(64'h1);

    // Asynchronous reset with keys queued and IRQ pending
    for (int i = 0; i < 5; i++) press(8'(8'h70 + i));
    read_data(v);
    chk("pre_rst_rdata", v, 64'h70);
    press(8'h75);
    chk("pre_rst_irq", {60'd0, irq_vector}, 64'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_rdata", bus_read_data, 64'h0);
    chk("async_rst_irq", {60'd0, irq_vector}, 64'h0);
    tick();
    reset = 1'b0;
    tick();
    read_stat(v);
    chk("post_rst_status", v, 64'h100);

`ifdef KEY_FIFO_BREAK_EN
    // Press then release yields make and break codes
    press(8'h61);
    key_released = 1'b1;
    tick();
    key_released = 1'b0;
    tick();
    read_data(v);
    chk("brk_make", v, 64'h61);
    read_data(v);
    chk("brk_break", v, 64'hE1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
